// File: rtl/pe_pkg.sv
// Shared definitions for the sequential priority scanner: state encoding and
// the ceil-log2 helper used to size index outputs.
package pe_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_e;

    function automatic int clog2(input int value);
        int res;
        int rem;
        res = 0;
        rem = value - 1;
        while (rem > 0) begin
            res = res + 1;
            rem = rem >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/pe_core.sv
// Combinational priority encoder: index of the highest (MSB_FIRST=1) or lowest
// (MSB_FIRST=0) set bit of vec_i, plus an any-bit-set flag.
module pe_core #(
    parameter int WIDTH     = 32,
    parameter int IDXW      = 5,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic [WIDTH-1:0] vec_i,
    output logic [IDXW-1:0]  idx_o,
    output logic             any_o
);

    // Later loop iterations overwrite earlier ones, so scan toward the winning end.
    always_comb begin
        idx_o = '0;
        any_o = |vec_i;
        if (MSB_FIRST) begin
            for (int i = 0; i < WIDTH; i++) begin
                idx_o = vec_i[i] ? IDXW'(i) : idx_o;
            end
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                idx_o = vec_i[i] ? IDXW'(i) : idx_o;
            end
        end
    end

endmodule

// File: rtl/pe_scan.sv
// Sequential priority scanner: accepts a request vector and emits the index of
// each set bit, one per output handshake, clearing each bit as it is granted.
module pe_scan
    import pe_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int IDXW      = clog2(WIDTH),
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDXW-1:0]  out_idx,
    output logic             out_last,
    output logic [IDXW:0]    remaining,
    output logic             empty
);

    localparam int CW = IDXW + 1;

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] pending_q;
    logic [WIDTH-1:0] pending_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic             empty_q;
    logic             empty_d;

    logic [IDXW-1:0]  core_idx_s;
    logic             core_any_s;
    logic             scan_s;
    logic             accept_s;
    logic             beat_s;
    logic             last_s;
    logic [CW-1:0]    vec_pop_s;

    pe_core #(
        .WIDTH     (WIDTH),
        .IDXW      (IDXW),
        .MSB_FIRST (MSB_FIRST)
    ) u_core (
        .vec_i (pending_q),
        .idx_o (core_idx_s),
        .any_o (core_any_s)
    );

    // flush blocks both handshakes in the cycle it is asserted.
    assign scan_s   = (state_q == ST_SCAN) && core_any_s;
    assign accept_s = in_valid && (state_q == ST_IDLE) && !flush;
    assign beat_s   = scan_s && out_ready && !flush;
    assign last_s   = scan_s && (cnt_q == CW'(1));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; an empty pending register in SCAN falls back to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s && (in_vec != '0)) begin
                    state_d = ST_SCAN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (flush || !core_any_s) begin
                    state_d = ST_IDLE;
                end else if (beat_s && last_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SCAN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode; index, last and count are forced to zero outside SCAN.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_idx   = '0;
        out_last  = 1'b0;
        remaining = '0;
        empty     = empty_q;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
            end
            ST_SCAN: begin
                out_valid = scan_s;
                out_idx   = scan_s ? core_idx_s : '0;
                out_last  = last_s;
                remaining = scan_s ? cnt_q : '0;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    // Population count of the incoming vector, loaded into the beat counter.
    always_comb begin
        vec_pop_s = '0;
        for (int i = 0; i < WIDTH; i++) begin
            vec_pop_s = vec_pop_s + CW'(in_vec[i]);
        end
    end

    // Pending vector, remaining count and zero-vector pulse next state.
    always_comb begin
        pending_d = pending_q;
        cnt_d     = cnt_q;
        empty_d   = 1'b0;
        if (flush) begin
            pending_d = '0;
            cnt_d     = '0;
        end else if (accept_s) begin
            pending_d = in_vec;
            cnt_d     = vec_pop_s;
            empty_d   = (in_vec == '0);
        end else if (beat_s) begin
            pending_d = pending_q & ~(WIDTH'(1) << core_idx_s);
            cnt_d     = cnt_q - CW'(1);
        end else begin
            pending_d = pending_q;
            cnt_d     = cnt_q;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= '0;
            cnt_q     <= '0;
            empty_q   <= 1'b0;
        end else begin
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            empty_q   <= empty_d;
        end
    end

endmodule

// File: tb/tb_pe_scan.sv
// Bench for pe_scan: three configurations (32/MSB, 32/LSB, 12/MSB) against a
// queue-of-indices reference model, with directed pins plus random traffic.
module tb_pe_scan;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] va;
    logic [31:0] vb;
    logic [11:0] vc;

    logic        ir0, ov0, ol0, em0;
    logic [4:0]  ix0;
    logic [5:0]  rm0;
    logic        ir1, ov1, ol1, em1;
    logic [4:0]  ix1;
    logic [5:0]  rm1;
    logic        ir2, ov2, ol2, em2;
    logic [3:0]  ix2;
    logic [4:0]  rm2;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    // Reference model: per instance, the ordered list of indices still owed.
    int mq [3][32];
    int mn [3];
    int mh [3];
    bit me [3];

    always #5 clk = ~clk;

    pe_scan #(.WIDTH(32), .MSB_FIRST(1'b1)) dut0 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir0),
        .in_vec(va), .out_valid(ov0), .out_ready(out_ready), .out_idx(ix0),
        .out_last(ol0), .remaining(rm0), .empty(em0)
    );

    pe_scan #(.WIDTH(32), .MSB_FIRST(1'b0)) dut1 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir1),
        .in_vec(vb), .out_valid(ov1), .out_ready(out_ready), .out_idx(ix1),
        .out_last(ol1), .remaining(rm1), .empty(em1)
    );

    pe_scan #(.WIDTH(12), .MSB_FIRST(1'b1)) dut2 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir2),
        .in_vec(vc), .out_valid(ov2), .out_ready(out_ready), .out_idx(ix2),
        .out_last(ol2), .remaining(rm2), .empty(em2)
    );

    task automatic chk(input string nm, input int act, input int exp);
        tot_cnt++;
        if (act == exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] vec_of(input int k);
        case (k)
            0:       return va;
            1:       return vb;
            default: return {20'd0, vc};
        endcase
    endfunction

    function automatic bit any_busy();
        return (mh[0] < mn[0]) || (mh[1] < mn[1]) || (mh[2] < mn[2]);
    endfunction

    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            int w;
            bit msb;
            logic [31:0] v;
            w   = (k == 2) ? 12 : 32;
            msb = (k != 1);
            v   = vec_of(k);
            if (reset || flush) begin
                mh[k] = 0;
                mn[k] = 0;
                me[k] = 1'b0;
            end else if (mh[k] < mn[k]) begin
                me[k] = 1'b0;
                if (out_ready) mh[k]++;
            end else begin
                me[k] = 1'b0;
                if (in_valid) begin
                    mh[k] = 0;
                    mn[k] = 0;
                    me[k] = (v == 32'd0);
                    for (int j = 0; j < w; j++) begin
                        int b;
                        b = msb ? (w - 1 - j) : j;
                        if (v[b]) begin
                            mq[k][mn[k]] = b;
                            mn[k]++;
                        end
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            int a_ir, a_ov, a_ix, a_ol, a_rm, a_em;
            bit busy;
            int rem;
            case (k)
                0: begin a_ir = int'(ir0); a_ov = int'(ov0); a_ix = int'(ix0);
                         a_ol = int'(ol0); a_rm = int'(rm0); a_em = int'(em0); end
                1: begin a_ir = int'(ir1); a_ov = int'(ov1); a_ix = int'(ix1);
                         a_ol = int'(ol1); a_rm = int'(rm1); a_em = int'(em1); end
                default: begin a_ir = int'(ir2); a_ov = int'(ov2); a_ix = int'(ix2);
                         a_ol = int'(ol2); a_rm = int'(rm2); a_em = int'(em2); end
            endcase
            busy = (mh[k] < mn[k]);
            rem  = busy ? (mn[k] - mh[k]) : 0;
            chk($sformatf("dut%0d in_ready", k), a_ir, busy ? 0 : 1);
            chk($sformatf("dut%0d out_valid", k), a_ov, busy ? 1 : 0);
            chk($sformatf("dut%0d out_idx", k), a_ix, busy ? mq[k][mh[k]] : 0);
            chk($sformatf("dut%0d out_last", k), a_ol, (rem == 1) ? 1 : 0);
            chk($sformatf("dut%0d remaining", k), a_rm, rem);
            chk($sformatf("dut%0d empty", k), a_em, me[k] ? 1 : 0);
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        flush     = 1'b0;
        reset     = 1'b0;
        for (int i = 0; i < 40 && any_busy(); i++) cycle();
        chk("drain completes", any_busy() ? 1 : 0, 0);
    endtask

    function automatic logic [31:0] pick();
        int r;
        r = $urandom % 8;
        if (r == 0) return 32'd0;
        if (r == 1) return 32'd1 << ($urandom % 32);
        return $urandom & $urandom & $urandom;
    endfunction

    initial begin
        logic [31:0] tmp;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        va = 32'd0; vb = 32'd0; vc = 12'd0;
        for (int k = 0; k < 3; k++) begin mn[k] = 0; mh[k] = 0; me[k] = 1'b0; end
        cycle();
        cycle();
        reset = 1'b0;
        chk("reset in_ready", int'(ir0), 1);
        chk("reset remaining", int'(rm0), 0);

        // Single bit, and the odd-width two-bit vector.
        va = 32'h2000_0000; vb = 32'h2000_0000; vc = 12'h801;
        in_valid = 1'b1; out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        chk("single idx", int'(ix0), 29);
        chk("single last", int'(ol0), 1);
        chk("single rem", int'(rm0), 1);
        chk("single model idx", mq[0][mh[0]], 29);
        chk("odd idx first", int'(ix2), 11);
        chk("odd rem", int'(rm2), 2);
        cycle();
        chk("single in_ready back", int'(ir0), 1);
        chk("odd idx second", int'(ix2), 0);
        chk("odd last", int'(ol2), 1);
        drain();

        // Multi-bit drain in both priority directions.
        va = 32'hF; vb = 32'hF; vc = 12'h0;
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        for (int j = 0; j < 4; j++) begin
            chk("msb drain idx", int'(ix0), 3 - j);
            chk("lsb drain idx", int'(ix1), j);
            chk("msb drain rem", int'(rm0), 4 - j);
            chk("msb drain last", int'(ol0), (j == 3) ? 1 : 0);
            cycle();
        end
        drain();

        // Backpressure holds outputs, then a full 16-beat drain.
        va = 32'h00FF_FF00; vb = 32'h00FF_FF00; vc = 12'hFF0;
        in_valid = 1'b1; out_ready = 1'b0;
        cycle();
        in_valid = 1'b0;
        for (int j = 0; j < 3; j++) begin
            chk("stall idx", int'(ix0), 23);
            chk("stall rem", int'(rm0), 16);
            chk("stall lsb idx", int'(ix1), 8);
            cycle();
        end
        out_ready = 1'b1;
        for (int j = 0; j < 16; j++) begin
            chk("bp drain idx", int'(ix0), 23 - j);
            cycle();
        end
        drain();

        // Zero vector produces a single-cycle empty pulse.
        va = 32'd0; vb = 32'd0; vc = 12'd0;
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        chk("zero empty", int'(em0), 1);
        chk("zero out_valid", int'(ov0), 0);
        cycle();
        chk("zero empty ends", int'(em0), 0);
        chk("zero in_ready", int'(ir0), 1);

        // Flush after two beats; the vector offered alongside flush is dropped.
        va = 32'h0000_FFFF; vb = 32'h0000_FFFF; vc = 12'hFFF;
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        chk("flush beat0", int'(ix0), 15);
        cycle();
        chk("flush beat1", int'(ix0), 14);
        cycle();
        flush = 1'b1; in_valid = 1'b1; va = 32'hFFFF_0000;
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush out_valid", int'(ov0), 0);
        chk("flush in_ready", int'(ir0), 1);
        cycle();
        chk("flush input dropped", int'(ov0), 0);

        // Reset mid-scan.
        va = 32'h0000_FFFF;
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("rst out_valid", int'(ov0), 0);
        chk("rst out_idx", int'(ix0), 0);
        chk("rst in_ready", int'(ir0), 1);

        va = 32'hFF; vb = 32'hFF; vc = 12'h0FF;
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        chk("post-reset idx", int'(ix0), 7);
        chk("post-reset lsb idx", int'(ix1), 0);
        drain();

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            in_valid  = ($urandom % 3) != 0;
            out_ready = ($urandom % 4) != 0;
            flush     = ($urandom % 40) == 0;
            reset     = ($urandom % 150) == 0;
            va  = pick();
            vb  = pick();
            tmp = pick();
            vc  = tmp[11:0];
            cycle();
        end
        drain();

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
